// File: rtl/sa_out_drain.sv
// Systolic-array output drain: captures one parallel result tile and streams
// it out row by row over a valid/ready handshake, flagging tiles that arrive while busy.
module sa_out_drain #(
  parameter int D_W  = 8,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int RI_W = $clog2(SA_R)
) (
  input  logic                                   I_CLK,
  input  logic                                   I_ASYN_RST,
  input  logic                                   I_SYNC_RSTN,
  input  logic                                   I_OUT_VLD,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]     I_OUT,
  output logic                                   O_READY,
  output logic                                   O_ROW_VLD,
  input  logic                                   I_ROW_RDY,
  output logic [0:SA_C-1][D_W-1:0]               O_ROW,
  output logic [RI_W-1:0]                        O_ROW_IDX,
  output logic                                   O_ROW_LAST,
  output logic                                   O_TILE_DONE,
  output logic                                   O_OVF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                               state_q, state_d;
  logic [RI_W-1:0]                      idx_q, idx_d;
  logic                                 ovf_q, ovf_d;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]   buf_q, buf_d;
  logic                                 capture;
  logic                                 last_row;

  assign last_row = (idx_q == RI_W'(SA_R - 1));

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    capture = 1'b0;
    if (!I_SYNC_RSTN) begin
      state_d = IDLE;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (I_OUT_VLD) begin
            capture = 1'b1;
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          // A tile offered while draining is dropped; only the sticky flag records it.
          if (I_OUT_VLD) ovf_d = 1'b1;
          if (I_ROW_RDY) begin
            if (last_row) begin
              idx_d   = '0;
              state_d = DONE;
            end else begin
              idx_d   = idx_q + RI_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign buf_d = capture ? I_OUT : buf_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the tile buffer has no reset; its contents are never visible outside DRAIN.
  always_ff @(posedge I_CLK) begin
    buf_q <= buf_d;
  end

  // Outputs decode straight from registered state, so reset reaches them without a clock.
  assign O_READY     = (state_q != DRAIN);
  assign O_ROW_VLD   = (state_q == DRAIN);
  assign O_ROW       = (state_q == DRAIN) ? buf_q[idx_q] : '0;
  assign O_ROW_IDX   = idx_q;
  assign O_ROW_LAST  = (state_q == DRAIN) && last_row;
  assign O_TILE_DONE = (state_q == DONE);
  assign O_OVF       = ovf_q;

endmodule

// File: tb/tb_sa_out_drain.sv
// Self-checking bench for sa_out_drain: a queue-of-rows reference model is
// advanced every edge and compared against the DUT after each edge.
module tb_sa_out_drain;

  localparam int D_W  = 8;
  localparam int SA_R = 16;
  localparam int SA_C = 16;
  localparam int RI_W = 4;

  typedef logic [0:SA_C-1][D_W-1:0]           row_t;
  typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0] tile_t;
  typedef logic [RI_W+4:0]                    flags_t;

  logic            I_CLK = 1'b0;
  logic            I_ASYN_RST;
  logic            I_SYNC_RSTN;
  logic            I_OUT_VLD;
  tile_t           I_OUT;
  logic            O_READY;
  logic            O_ROW_VLD;
  logic            I_ROW_RDY;
  row_t            O_ROW;
  logic [RI_W-1:0] O_ROW_IDX;
  logic            O_ROW_LAST;
  logic            O_TILE_DONE;
  logic            O_OVF;
  flags_t          dut_flags;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: rows still owed downstream, plus done pulse and sticky overflow.
  row_t m_rows[$];
  bit   m_done;
  bit   m_ovf;

  sa_out_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .RI_W(RI_W)) dut (
    .I_CLK(I_CLK), .I_ASYN_RST(I_ASYN_RST), .I_SYNC_RSTN(I_SYNC_RSTN),
    .I_OUT_VLD(I_OUT_VLD), .I_OUT(I_OUT), .O_READY(O_READY),
    .O_ROW_VLD(O_ROW_VLD), .I_ROW_RDY(I_ROW_RDY), .O_ROW(O_ROW),
    .O_ROW_IDX(O_ROW_IDX), .O_ROW_LAST(O_ROW_LAST),
    .O_TILE_DONE(O_TILE_DONE), .O_OVF(O_OVF)
  );

  always #5 I_CLK = ~I_CLK;

  assign dut_flags = {O_READY, O_ROW_VLD, O_ROW_IDX, O_ROW_LAST, O_TILE_DONE, O_OVF};

  function automatic flags_t exp_flags();
    int sz;
    logic [RI_W-1:0] idx;
    sz  = m_rows.size();
    idx = (sz == 0) ? '0 : RI_W'(SA_R - sz);
    return {sz == 0, sz != 0, idx, sz == 1, m_done, m_ovf};
  endfunction

  function automatic row_t exp_row();
    return (m_rows.size() != 0) ? m_rows[0] : '0;
  endfunction

  function automatic void model_clear();
    m_rows.delete();
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_edge(bit vld, bit rdy, bit srst_n, tile_t t);
    bit nd;
    nd = 1'b0;
    if (!srst_n) begin
      m_rows.delete();
      m_ovf = 1'b0;
    end else if (m_rows.size() != 0) begin
      if (vld) m_ovf = 1'b1;
      if (rdy) begin
        void'(m_rows.pop_front());
        if (m_rows.size() == 0) nd = 1'b1;
      end
    end else if (vld) begin
      for (int r = 0; r < SA_R; r++) m_rows.push_back(t[r]);
    end
    m_done = nd;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) t[r][c] = D_W'($urandom);
    return t;
  endfunction

  function automatic tile_t ramp_tile();
    tile_t t;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) t[r][c] = D_W'(r * 16 + c);
    return t;
  endfunction

  function automatic row_t ramp_row(int r);
    row_t x;
    for (int c = 0; c < SA_C; c++) x[c] = D_W'(r * 16 + c);
    return x;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it.
  task automatic step(input bit vld, input bit rdy, input bit srst_n, input tile_t t);
    I_OUT_VLD   = vld;
    I_ROW_RDY   = rdy;
    I_SYNC_RSTN = srst_n;
    I_OUT       = t;
    @(posedge I_CLK);
    model_edge(vld, rdy, srst_n, t);
    #1;
    I_OUT_VLD   = 1'b0;
    I_SYNC_RSTN = 1'b1;
  endtask

  task automatic test_reset();
    flags_t rst_flags;
    rst_flags = {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    #3;
    n_total++;
    if (dut_flags !== rst_flags || O_ROW !== '0) begin
      n_bad++;
      $display("FAIL power_on_reset: got flags=%b row=%h expected flags=%b row=0", dut_flags, O_ROW, rst_flags);
    end
    #9 I_ASYN_RST = 1'b0;
    @(posedge I_CLK);
    #1;
    model_clear();
    step(1'b1, 1'b1, 1'b1, rand_tile());
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, '0);
    #2 I_ASYN_RST = 1'b1;
    #1;
    model_clear();
    n_total++;
    if (dut_flags !== rst_flags || O_ROW !== '0) begin
      n_bad++;
      $display("FAIL async_reset_mid_drain: got flags=%b row=%h expected flags=%b row=0", dut_flags, O_ROW, rst_flags);
    end
    #2 I_ASYN_RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, '0);
      n_total++;
      if (dut_flags !== exp_flags() || O_ROW !== exp_row()) begin
        n_bad++;
        $display("FAIL after_async_reset cyc=%0d: got flags=%b expected flags=%b", k, dut_flags, exp_flags());
      end
    end
  endtask

  task automatic test_full_drain();
    int done_k, last_cnt, last_k;
    done_k = -1; last_cnt = 0; last_k = -1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, ramp_tile());
    for (int k = 1; k <= 18; k++) begin
      n_total++;
      if (dut_flags !== exp_flags() || O_ROW !== exp_row()) begin
        n_bad++;
        $display("FAIL full_drain_model cyc=%0d: got flags=%b row=%h expected flags=%b row=%h",
                 k, dut_flags, O_ROW, exp_flags(), exp_row());
      end
      if (k <= 16) begin
        n_total++;
        if (O_ROW !== ramp_row(k - 1) || O_ROW_VLD !== 1'b1) begin
          n_bad++;
          $display("FAIL full_drain_row cyc=%0d: got vld=%b row=%h expected vld=1 row=%h", k, O_ROW_VLD, O_ROW, ramp_row(k - 1));
        end
      end
      if (O_TILE_DONE === 1'b1 && done_k < 0) done_k = k;
      if (O_ROW_LAST === 1'b1) begin last_cnt++; last_k = k; end
      step(1'b0, 1'b1, 1'b1, '0);
    end
    n_total++;
    if (done_k != 17) begin
      n_bad++;
      $display("FAIL full_drain_done_cycle: got %0d expected 17", done_k);
    end
    n_total++;
    if (last_cnt != 1 || last_k != 16) begin
      n_bad++;
      $display("FAIL full_drain_last: got count=%0d at cyc=%0d expected count=1 at cyc=16", last_cnt, last_k);
    end
  endtask

  task automatic test_backpressure();
    int done_k, stalls, held;
    bit rdy;
    done_k = -1; stalls = 0; held = 0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, ramp_tile());
    for (int k = 1; k <= 24; k++) begin
      n_total++;
      if (dut_flags !== exp_flags() || O_ROW !== exp_row()) begin
        n_bad++;
        $display("FAIL backpressure_model cyc=%0d: got flags=%b row=%h expected flags=%b row=%h",
                 k, dut_flags, O_ROW, exp_flags(), exp_row());
      end
      if (O_ROW_VLD === 1'b1 && O_ROW_IDX === 4'd3 && O_ROW === ramp_row(3)) held++;
      if (O_TILE_DONE === 1'b1 && done_k < 0) done_k = k;
      rdy = 1'b1;
      if (m_rows.size() == SA_R - 3 && stalls < 5) begin
        rdy = 1'b0;
        stalls++;
      end
      step(1'b0, rdy, 1'b1, '0);
    end
    n_total++;
    if (held != 6) begin
      n_bad++;
      $display("FAIL backpressure_hold: got %0d cycles expected 6", held);
    end
    n_total++;
    if (done_k != 22) begin
      n_bad++;
      $display("FAIL backpressure_done_cycle: got %0d expected 22", done_k);
    end
  endtask

  task automatic test_overflow();
    tile_t ff_tile;
    int    vld_after;
    ff_tile = '1;
    vld_after = 0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, ramp_tile());
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, '0);
    n_total++;
    if (O_ROW_IDX !== 4'd5 || O_OVF !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_setup: got idx=%0d ovf=%b expected idx=5 ovf=0", O_ROW_IDX, O_OVF);
    end
    step(1'b1, 1'b1, 1'b1, ff_tile);
    for (int k = 0; k < 18; k++) begin
      n_total++;
      if (dut_flags !== exp_flags() || O_ROW !== exp_row()) begin
        n_bad++;
        $display("FAIL overflow_model cyc=%0d: got flags=%b row=%h expected flags=%b row=%h",
                 k, dut_flags, O_ROW, exp_flags(), exp_row());
      end
      if (k >= 12 && O_ROW_VLD === 1'b1) vld_after++;
      step(1'b0, 1'b1, 1'b1, '0);
    end
    n_total++;
    if (O_OVF !== 1'b1 || vld_after != 0) begin
      n_bad++;
      $display("FAIL overflow_sticky: got ovf=%b extra_rows=%0d expected ovf=1 extra_rows=0", O_OVF, vld_after);
    end
  endtask

  task automatic test_sync_clear();
    tile_t t2;
    int    dones;
    dones = 0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, ramp_tile());
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b1, '0);
    n_total++;
    if (O_ROW_IDX !== 4'd7) begin
      n_bad++;
      $display("FAIL sync_clear_setup: got idx=%0d expected 7", O_ROW_IDX);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    n_total++;
    if (O_ROW_VLD !== 1'b0 || O_READY !== 1'b1 || O_ROW_IDX !== 4'd0 || O_ROW !== '0) begin
      n_bad++;
      $display("FAIL sync_clear_outputs: got vld=%b ready=%b idx=%0d expected vld=0 ready=1 idx=0", O_ROW_VLD, O_READY, O_ROW_IDX);
    end
    for (int k = 0; k < 20; k++) begin
      if (O_TILE_DONE === 1'b1) dones++;
      step(1'b0, 1'b1, 1'b1, '0);
    end
    n_total++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL sync_clear_no_done: got %0d done pulses expected 0", dones);
    end
    step(1'b1, 1'b1, 1'b0, rand_tile());
    n_total++;
    if (dut_flags !== exp_flags() || O_ROW_VLD !== 1'b0 || O_OVF !== 1'b0) begin
      n_bad++;
      $display("FAIL sync_clear_priority: got flags=%b expected flags=%b", dut_flags, exp_flags());
    end
    t2 = rand_tile();
    step(1'b1, 1'b1, 1'b1, t2);
    n_total++;
    if (O_ROW_VLD !== 1'b1 || O_ROW_IDX !== 4'd0 || O_ROW !== t2[0]) begin
      n_bad++;
      $display("FAIL sync_clear_restart: got vld=%b idx=%0d row=%h expected vld=1 idx=0 row=%h", O_ROW_VLD, O_ROW_IDX, O_ROW, t2[0]);
    end
  endtask

  task automatic test_back_to_back();
    tile_t ta, tb;
    ta = rand_tile();
    tb = rand_tile();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, ta);
    for (int k = 0; k < SA_R; k++) step(1'b0, 1'b1, 1'b1, '0);
    n_total++;
    if (O_TILE_DONE !== 1'b1 || O_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done_cycle: got done=%b ready=%b expected done=1 ready=1", O_TILE_DONE, O_READY);
    end
    step(1'b1, 1'b1, 1'b1, tb);
    n_total++;
    if (O_ROW_VLD !== 1'b1 || O_ROW !== tb[0] || O_OVF !== 1'b0 || O_TILE_DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_capture: got vld=%b ovf=%b row=%h expected vld=1 ovf=0 row=%h", O_ROW_VLD, O_OVF, O_ROW, tb[0]);
    end
    for (int k = 0; k < SA_R + 2; k++) begin
      step(1'b0, 1'b1, 1'b1, '0);
      n_total++;
      if (dut_flags !== exp_flags() || O_ROW !== exp_row()) begin
        n_bad++;
        $display("FAIL b2b_model cyc=%0d: got flags=%b row=%h expected flags=%b row=%h",
                 k, dut_flags, O_ROW, exp_flags(), exp_row());
      end
    end
  endtask

  task automatic test_random();
    bit vld, rdy, srst_n;
    step(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 800; k++) begin
      vld    = ($urandom % 6) == 0;
      rdy    = ($urandom % 3) != 0;
      srst_n = ($urandom % 80) != 0;
      step(vld, rdy, srst_n, rand_tile());
      n_total++;
      if (dut_flags !== exp_flags() || O_ROW !== exp_row()) begin
        n_bad++;
        $display("FAIL random_model cyc=%0d: got flags=%b row=%h expected flags=%b row=%h",
                 k, dut_flags, O_ROW, exp_flags(), exp_row());
      end
    end
  endtask

  initial begin
    I_ASYN_RST  = 1'b1;
    I_SYNC_RSTN = 1'b1;
    I_OUT_VLD   = 1'b0;
    I_ROW_RDY   = 1'b0;
    I_OUT       = '0;
    model_clear();
    test_reset();
    test_full_drain();
    test_backpressure();
    test_overflow();
    test_sync_clear();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
